// File: rtl/sha3_pkg.sv
// Shared SHA-3 types for the digest transmit path: Keccak state layout, mode encoding, FSM states.
package sha3_pkg;

    typedef logic [0:4][0:4][63:0] keccak_state_t;

    typedef enum logic [1:0] {SHA3_224, SHA3_256, SHA3_384, SHA3_512} sha3_mode_t;

    typedef enum logic {IDLE, SEND} tx_state_t;

    localparam int unsigned DIGEST_MAX = 512;

    function automatic logic [9:0] digest_bits(input sha3_mode_t m);
        case (m)
            SHA3_224: return 10'd224;
            SHA3_256: return 10'd256;
            SHA3_384: return 10'd384;
            default:  return 10'd512;
        endcase
    endfunction

endpackage

// File: rtl/axis_digest_tx_if.sv
// AXI-Stream bundle carrying digest beats; TID carries the SHA-3 mode of the packet.
interface axis_digest_tx_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  TVALID;
    logic                  TREADY;
    logic [DATA_WIDTH-1:0] TDATA;
    logic                  TLAST;
    logic [1:0]            TID;

    modport master (output TVALID, TDATA, TLAST, TID, input TREADY);
    modport slave  (input TVALID, TDATA, TLAST, TID, output TREADY);
endinterface

// File: rtl/sha3_digest_select.sv
// Combinational: flattens the Keccak state lane-by-lane and keeps only the digest bits of the mode.
module sha3_digest_select
    import sha3_pkg::*;
(
    input  keccak_state_t           S_in,
    input  sha3_mode_t              mode,
    output logic [DIGEST_MAX-1:0]   digest
);
    logic [25*64-1:0] flat;
    logic             unused_upper_lanes;

    always_comb begin
        flat = '0;
        for (int x = 0; x < 5; x++) begin
            for (int y = 0; y < 5; y++) begin
                flat[64*(5*x+y) +: 64] = S_in[x][y];
            end
        end
    end

    // Lanes above 512 bits never reach any digest length.
    assign unused_upper_lanes = ^flat[25*64-1:DIGEST_MAX];

    always_comb begin
        digest = '0;
        for (int i = 0; i < DIGEST_MAX; i++) begin
            if (10'(i) < digest_bits(mode)) digest[i] = flat[i];
        end
    end
endmodule

// File: rtl/axis_digest_tx.sv
// AXI-Stream master serialising the SHA-3 digest LSB-first, DATA_WIDTH bits per beat.
// Optional build macro SHA3_TX_BYTESWAP_EN byte-reverses each beat at the output.
module axis_digest_tx
    import sha3_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic                start,
    input  logic [1:0]          mode,
    input  keccak_state_t       S_in,
    output logic                busy,
    output logic                done,
    axis_digest_tx_if.master    m_axis
);
    if (DATA_WIDTH != 8 && DATA_WIDTH != 16 && DATA_WIDTH != 32) begin : g_bad_width
        $error("axis_digest_tx: DATA_WIDTH must be 8, 16 or 32");
    end

    function automatic logic [5:0] last_beat(input sha3_mode_t m);
        return 6'((int'(digest_bits(m)) / DATA_WIDTH) - 1);
    endfunction

    logic [DIGEST_MAX-1:0] digest_sel;
    logic [DIGEST_MAX-1:0] digest_r;
    tx_state_t             state;
    sha3_mode_t            mode_r;
    logic [5:0]            cnt;
    logic                  tvalid_r;
    logic                  tlast_r;
    logic                  handshake;
    logic [DATA_WIDTH-1:0] beat;
    logic [DATA_WIDTH-1:0] tdata;

    sha3_digest_select u_select (
        .S_in   (S_in),
        .mode   (sha3_mode_t'(mode)),
        .digest (digest_sel)
    );

    assign handshake = tvalid_r && m_axis.TREADY;

    // The digest register shifts right per beat, so the current beat is always its low slice.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state    <= IDLE;
            mode_r   <= SHA3_224;
            cnt      <= '0;
            digest_r <= '0;
            tvalid_r <= 1'b0;
            tlast_r  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        digest_r <= digest_sel;
                        mode_r   <= sha3_mode_t'(mode);
                        cnt      <= '0;
                        tvalid_r <= 1'b1;
                        tlast_r  <= 1'b0;
                        busy     <= 1'b1;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (handshake) begin
                        if (cnt == last_beat(mode_r)) begin
                            digest_r <= '0;
                            tvalid_r <= 1'b0;
                            tlast_r  <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            digest_r <= digest_r >> DATA_WIDTH;
                            cnt      <= cnt + 6'd1;
                            tlast_r  <= (cnt + 6'd1 == last_beat(mode_r));
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign beat = digest_r[DATA_WIDTH-1:0];

`ifdef SHA3_TX_BYTESWAP_EN
    always_comb begin
        tdata = '0;
        for (int b = 0; b < DATA_WIDTH/8; b++) begin
            tdata[DATA_WIDTH-1-8*b -: 8] = beat[8*b +: 8];
        end
    end
`else
    assign tdata = beat;
`endif

    assign m_axis.TVALID = tvalid_r;
    assign m_axis.TDATA  = tdata;
    assign m_axis.TLAST  = tlast_r;
    assign m_axis.TID    = mode_r;
endmodule

// File: tb/tb_axis_digest_tx.sv
// Directed bench for axis_digest_tx at DATA_WIDTH=16 with a small digest model and hand-computed beats.
module tb_axis_digest_tx;
    import sha3_pkg::*;

    logic          ACLK = 1'b0;
    logic          ARESETn;
    logic          start;
    logic [1:0]    mode_i;
    keccak_state_t st;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    logic [511:0] exp_d;
    logic [1:0]   cur_mode;
    int           cur_n;
    logic [15:0]  obs_beats [0:63];

    axis_digest_tx_if #(.DATA_WIDTH(16)) m_axis ();

    axis_digest_tx #(.DATA_WIDTH(16)) dut (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .start   (start),
        .mode    (mode_i),
        .S_in    (st),
        .busy    (busy),
        .done    (done),
        .m_axis  (m_axis)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] sw(input logic [15:0] v);
`ifdef SHA3_TX_BYTESWAP_EN
        return {v[7:0], v[15:8]};
`else
        return v;
`endif
    endfunction

    function automatic int len_bits(input logic [1:0] m);
        case (m)
            2'd0:    return 224;
            2'd1:    return 256;
            2'd2:    return 384;
            default: return 512;
        endcase
    endfunction

    function automatic logic [511:0] model_digest(input keccak_state_t s, input logic [1:0] m);
        logic [511:0] d;
        d = '0;
        for (int lane = 0; lane < 8; lane++) d[64*lane +: 64] = s[lane/5][lane%5];
        for (int b = 0; b < 512; b++) if (b >= len_bits(m)) d[b] = 1'b0;
        return d;
    endfunction

    task automatic do_start(input logic [1:0] m);
        cur_mode = m;
        cur_n    = len_bits(m) / 16;
        exp_d    = model_digest(st, m);
        start    = 1'b1;
        mode_i   = m;
        @(posedge ACLK); #1;
        start    = 1'b0;
        chk("start_tvalid", 64'(m_axis.TVALID), 64'd1);
        chk("start_busy", 64'(busy), 64'd1);
    endtask

    // rdy_toggle: TREADY follows 1,0,0,1; inject_at: pulse start and scramble S_in at that beat;
    // abort_at: assert reset while that beat is presented.
    task automatic run_pkt(input bit rdy_toggle, input int inject_at, input int abort_at);
        int          i = 0;
        int          cyc = 0;
        int          nlast = 0;
        bit          stalled = 0;
        bit          injected = 0;
        bit          hs;
        logic [15:0] prev_d = '0;
        logic        prev_l = 1'b0;
        while (i < cur_n && cyc < 400) begin
            if (i == abort_at) begin
                ARESETn = 1'b0;
                @(posedge ACLK); #1;
                chk("abort_tvalid", 64'(m_axis.TVALID), 64'd0);
                chk("abort_busy", 64'(busy), 64'd0);
                chk("abort_tlast", 64'(m_axis.TLAST), 64'd0);
                ARESETn = 1'b1;
                return;
            end
            m_axis.TREADY = rdy_toggle ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
            if (stalled) begin
                chk("stall_tdata", 64'(m_axis.TDATA), 64'(prev_d));
                chk("stall_tlast", 64'(m_axis.TLAST), 64'(prev_l));
            end
            chk("beat_tvalid", 64'(m_axis.TVALID), 64'd1);
            chk("beat_tdata", 64'(m_axis.TDATA), 64'(sw(exp_d[16*i +: 16])));
            chk("beat_tlast", 64'(m_axis.TLAST), 64'(i == cur_n - 1));
            chk("beat_tid", 64'(m_axis.TID), 64'(cur_mode));
            if (i == inject_at && !injected) begin
                start    = 1'b1;
                mode_i   = 2'd3;
                st[0][0] = ~st[0][0];
                st[0][1] = 64'h5555_AAAA_5555_AAAA;
                injected = 1;
            end else begin
                start = 1'b0;
            end
            hs = m_axis.TREADY;
            if (hs) begin
                obs_beats[i] = m_axis.TDATA;
                if (m_axis.TLAST) nlast++;
            end
            stalled = !hs;
            prev_d  = m_axis.TDATA;
            prev_l  = m_axis.TLAST;
            @(posedge ACLK); #1;
            cyc++;
            if (hs) i++;
        end
        start = 1'b0;
        m_axis.TREADY = 1'b1;
        chk("pkt_complete", 64'(i), 64'(cur_n));
        chk("pkt_one_tlast", 64'(nlast), 64'd1);
        chk("end_done", 64'(done), 64'd1);
        chk("end_busy", 64'(busy), 64'd0);
        chk("end_tvalid_gap", 64'(m_axis.TVALID), 64'd0);
    endtask

    initial begin
        int ff_beats;
        ARESETn = 1'b0;
        start   = 1'b0;
        mode_i  = 2'd0;
        st      = '0;
        m_axis.TREADY = 1'b0;
        repeat (3) @(posedge ACLK);
        #1;
        chk("rst_tvalid", 64'(m_axis.TVALID), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_tlast", 64'(m_axis.TLAST), 64'd0);
        chk("rst_tdata", 64'(m_axis.TDATA), 64'd0);
        chk("rst_tid", 64'(m_axis.TID), 64'd0);
        ARESETn = 1'b1;
        m_axis.TREADY = 1'b1;
        @(posedge ACLK); #1;
        chk("idle_tvalid", 64'(m_axis.TVALID), 64'd0);

        // T1: SHA3-256, single non-zero lane, TREADY held high
        st[0][0] = 64'h0123_4567_89AB_CDEF;
        do_start(2'd1);
`ifdef SHA3_TX_BYTESWAP_EN
        chk("t1_beat0", 64'(m_axis.TDATA), 64'h0000_0000_0000_EFCD);
`else
        chk("t1_beat0", 64'(m_axis.TDATA), 64'h0000_0000_0000_CDEF);
`endif
        run_pkt(1'b0, -1, -1);
        chk("t1_beat1", 64'(obs_beats[1]), 64'(sw(16'h89AB)));
        chk("t1_beat2", 64'(obs_beats[2]), 64'(sw(16'h4567)));
        chk("t1_beat3", 64'(obs_beats[3]), 64'(sw(16'h0123)));
        chk("t1_beat4", 64'(obs_beats[4]), 64'd0);
        chk("t1_beat15", 64'(obs_beats[15]), 64'd0);

        // Start in the done cycle: accepted, leaving a single-cycle TVALID gap
        do_start(2'd1);
        run_pkt(1'b0, -1, -1);
        chk("b2b_beat0", 64'(obs_beats[0]), 64'(sw(16'hCDEF)));

        // T2: SHA3-224, lane [0][3] truncated, lane [3][2] all ones must not appear
        st       = '0;
        st[0][0] = 64'h1111_2222_3333_4444;
        st[0][1] = 64'h5555_6666_7777_8888;
        st[0][2] = 64'h9999_AAAA_BBBB_CCCC;
        st[0][3] = 64'hDEAD_BEEF_CAFE_F00D;
        st[0][4] = 64'h0F0F_0F0F_0F0F_0F0F;
        st[3][2] = '1;
        do_start(2'd0);
        run_pkt(1'b0, -1, -1);
        chk("t2_beat0", 64'(obs_beats[0]), 64'(sw(16'h4444)));
        chk("t2_beat11", 64'(obs_beats[11]), 64'(sw(16'h9999)));
        chk("t2_beat12", 64'(obs_beats[12]), 64'(sw(16'hF00D)));
        chk("t2_beat13", 64'(obs_beats[13]), 64'(sw(16'hCAFE)));
        ff_beats = 0;
        for (int k = 0; k < 14; k++) if (obs_beats[k] == 16'hFFFF) ff_beats++;
        chk("t2_no_lane32", 64'(ff_beats), 64'd0);

        // T3: SHA3-512 with TREADY stalls
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                st[x][y] = {$urandom, $urandom};
        do_start(2'd3);
        run_pkt(1'b1, -1, -1);
        chk("t3_beat31", 64'(obs_beats[31]), 64'(sw(st[1][2][63:48])));

        // T4: second start mid-packet with S_in changed afterwards
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                st[x][y] = {$urandom, $urandom};
        do_start(2'd1);
        run_pkt(1'b0, 5, -1);
        for (int k = 0; k < 3; k++) begin
            @(posedge ACLK); #1;
            chk("t4_no_repacket", 64'(m_axis.TVALID), 64'd0);
        end
        chk("t4_done_pulse", 64'(done), 64'd0);

        // T5: reset at beat 7 of SHA3-384, then a full packet
        do_start(2'd2);
        run_pkt(1'b0, -1, 7);
        chk("t5_tid_cleared", 64'(m_axis.TID), 64'd0);
        do_start(2'd2);
        run_pkt(1'b0, -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
